jtag_tap_fsm: RTL and testbench



---
 rtl/jtag_tap_fsm_if.sv | 38 +++
 rtl/jtag_tap_fsm.sv | 108 ++++++++++
 tb/tb_jtag_tap_fsm.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_fsm_if.sv
// Interface between the TAP controller and the IR/DR scan cells: tms in, scan strobes out.
// Defining TAP_STATE_OBS_EN adds the tap_state observation bus.
interface jtag_tap_fsm_if;
  logic       tms;
  logic       tap_reset_n;
  logic       shiftIR;
  logic       clockIR;
  logic       updateIR;
  logic       shiftDR;
  logic       clockDR;
  logic       updateDR;
  logic       select;
  logic       tdo_en;
  logic       run_idle;
`ifdef TAP_STATE_OBS_EN
  logic [3:0] tap_state;
`endif

  modport master (
    input  tms,
    output tap_reset_n, shiftIR, clockIR, updateIR,
    output shiftDR, clockDR, updateDR,
    output select, tdo_en, run_idle
`ifdef TAP_STATE_OBS_EN
    , output tap_state
`endif
  );

  modport slave (
    output tms,
    input  tap_reset_n, shiftIR, clockIR, updateIR,
    input  shiftDR, clockDR, updateDR,
    input  select, tdo_en, run_idle
`ifdef TAP_STATE_OBS_EN
    , input tap_state
`endif
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller with Moore-decoded IR/DR scan strobes in the tck domain.
// Optional TAP_STATE_OBS_EN exports the IEEE state code as tap_state[3:0].
module jtag_tap_fsm #(
  parameter int unsigned Encoding = 0,
  parameter int unsigned SyncMode = 1
) (
  input logic            i_tck,
  input logic            i_trst_n,
  jtag_tap_fsm_if.master io_tap
);

  typedef enum logic [3:0] {
    StEx2Dr = 4'h0,
    StEx1Dr = 4'h1,
    StShDr  = 4'h2,
    StPauDr = 4'h3,
    StSelIr = 4'h4,
    StUpdDr = 4'h5,
    StCapDr = 4'h6,
    StSelDr = 4'h7,
    StEx2Ir = 4'h8,
    StEx1Ir = 4'h9,
    StShIr  = 4'hA,
    StPauIr = 4'hB,
    StRti   = 4'hC,
    StUpdIr = 4'hD,
    StCapIr = 4'hE,
    StTlr   = 4'hF
  } tap_state_e;

  localparam int unsigned StW = (Encoding == 1) ? 16 : 4;
  localparam logic [StW-1:0] RstVal = (Encoding == 1) ? StW'(32'h8000) : StW'(32'hF);

  logic [StW-1:0] r_state;
  logic [StW-1:0] w_state_next;
  tap_state_e     w_cur;
  tap_state_e     w_next;
  logic           w_illegal;
  logic           w_clock_ir;
  logic           w_clock_dr;

  if (Encoding == 1) begin : g_onehot
    // Zero or multiple hot bits decode as TLR and force TLR on the next edge.
    always_comb begin
      w_cur = StTlr;
      for (int i = 0; i < 16; i++) begin
        if (r_state[i]) w_cur = tap_state_e'(i[3:0]);
      end
      w_illegal = !$onehot(r_state);
      if (w_illegal) w_cur = StTlr;
    end
    assign w_state_next = StW'(1) << w_next;
  end else begin : g_binary
    assign w_cur        = tap_state_e'(r_state);
    assign w_illegal    = 1'b0;
    assign w_state_next = w_next;
  end

  always_ff @(posedge i_tck) begin
    if (!i_trst_n) r_state <= RstVal;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_next = StTlr;
    if (!w_illegal) begin
      unique case (w_cur)
        StTlr:   w_next = io_tap.tms ? StTlr   : StRti;
        StRti:   w_next = io_tap.tms ? StSelDr : StRti;
        StSelDr: w_next = io_tap.tms ? StSelIr : StCapDr;
        StCapDr: w_next = io_tap.tms ? StEx1Dr : StShDr;
        StShDr:  w_next = io_tap.tms ? StEx1Dr : StShDr;
        StEx1Dr: w_next = io_tap.tms ? StUpdDr : StPauDr;
        StPauDr: w_next = io_tap.tms ? StEx2Dr : StPauDr;
        StEx2Dr: w_next = io_tap.tms ? StUpdDr : StShDr;
        StUpdDr: w_next = io_tap.tms ? StSelDr : StRti;
        StSelIr: w_next = io_tap.tms ? StTlr   : StCapIr;
        StCapIr: w_next = io_tap.tms ? StEx1Ir : StShIr;
        StShIr:  w_next = io_tap.tms ? StEx1Ir : StShIr;
        StEx1Ir: w_next = io_tap.tms ? StUpdIr : StPauIr;
        StPauIr: w_next = io_tap.tms ? StEx2Ir : StPauIr;
        StEx2Ir: w_next = io_tap.tms ? StUpdIr : StShIr;
        StUpdIr: w_next = io_tap.tms ? StSelDr : StRti;
        default: w_next = StTlr;
      endcase
    end
  end

  assign w_clock_ir = (w_cur == StCapIr) || (w_cur == StShIr);
  assign w_clock_dr = (w_cur == StCapDr) || (w_cur == StShDr);

  assign io_tap.tap_reset_n = (w_cur != StTlr);
  assign io_tap.shiftIR     = (w_cur == StShIr);
  assign io_tap.clockIR     = (SyncMode != 0) ? w_clock_ir : !w_clock_ir;
  assign io_tap.updateIR    = (w_cur == StUpdIr);
  assign io_tap.shiftDR     = (w_cur == StShDr);
  assign io_tap.clockDR     = (SyncMode != 0) ? w_clock_dr : !w_clock_dr;
  assign io_tap.updateDR    = (w_cur == StUpdDr);
  assign io_tap.select      = w_cur inside {StSelIr, StCapIr, StShIr, StEx1Ir,
                                            StPauIr, StEx2Ir, StUpdIr};
  assign io_tap.tdo_en      = (w_cur == StShIr) || (w_cur == StShDr);
  assign io_tap.run_idle    = (w_cur == StRti);

`ifdef TAP_STATE_OBS_EN
  assign io_tap.tap_state = w_cur;
`endif

endmodule

// File: tb/tb_jtag_tap_fsm.sv
// Bench for jtag_tap_fsm: binary/sync and one-hot/inverted-clock builds run in lockstep
// against a state-table reference model; TAP_STATE_OBS_EN also checks tap_state.
module tb_jtag_tap_fsm;

  logic tck;
  logic trst_n;
  logic tms;

  jtag_tap_fsm_if if0 ();
  jtag_tap_fsm_if if1 ();

  assign if0.tms = tms;
  assign if1.tms = tms;

  jtag_tap_fsm #(.Encoding(0), .SyncMode(1)) dut0 (
    .i_tck    (tck),
    .i_trst_n (trst_n),
    .io_tap   (if0)
  );

  jtag_tap_fsm #(.Encoding(1), .SyncMode(0)) dut1 (
    .i_tck    (tck),
    .i_trst_n (trst_n),
    .io_tap   (if1)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  // {tap_reset_n, shiftIR, clockIR, updateIR, shiftDR, clockDR, updateDR, select, tdo_en, run_idle}
  logic [9:0] out0;
  logic [9:0] out1;
  assign out0 = {if0.tap_reset_n, if0.shiftIR, if0.clockIR, if0.updateIR, if0.shiftDR,
                 if0.clockDR, if0.updateDR, if0.select, if0.tdo_en, if0.run_idle};
  assign out1 = {if1.tap_reset_n, if1.shiftIR, if1.clockIR, if1.updateIR, if1.shiftDR,
                 if1.clockDR, if1.updateDR, if1.select, if1.tdo_en, if1.run_idle};

  localparam logic [9:0] OTlr    = 10'b0000000000;
  localparam logic [9:0] ORti    = 10'b1000000001;
  localparam logic [9:0] OSelDr  = 10'b1000000000;
  localparam logic [9:0] OCapDr  = 10'b1000010000;
  localparam logic [9:0] OShDr   = 10'b1000110010;
  localparam logic [9:0] ODrIdle = 10'b1000000000;
  localparam logic [9:0] OUpdDr  = 10'b1000001000;
  localparam logic [9:0] OSelIr  = 10'b1000000100;
  localparam logic [9:0] OCapIr  = 10'b1010000100;
  localparam logic [9:0] OShIr   = 10'b1110000110;
  localparam logic [9:0] OIrIdle = 10'b1000000100;
  localparam logic [9:0] OUpdIr  = 10'b1001000100;
  // clockIR/clockDR flip polarity in the SyncMode=0 build
  localparam logic [9:0] InvMask = 10'b0010010000;

  // Next-state tables indexed by IEEE state code, for tms=0 and tms=1.
  int nxt0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
  int nxt1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

  int m_state = 15;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rst_n;
    bit         tms;
    int         st;
    logic [9:0] out;
  } vec_t;

  vec_t vecs [30] = '{
    '{1'b0, 1'b1, 15, OTlr},
    '{1'b1, 1'b0, 12, ORti},
    '{1'b1, 1'b1,  7, OSelDr},
    '{1'b1, 1'b1,  4, OSelIr},
    '{1'b1, 1'b0, 14, OCapIr},
    '{1'b1, 1'b0, 10, OShIr},
    '{1'b1, 1'b0, 10, OShIr},
    '{1'b1, 1'b0, 10, OShIr},
    '{1'b1, 1'b0, 10, OShIr},
    '{1'b1, 1'b0, 10, OShIr},
    '{1'b1, 1'b1,  9, OIrIdle},
    '{1'b1, 1'b1, 13, OUpdIr},
    '{1'b1, 1'b0, 12, ORti},
    '{1'b1, 1'b1,  7, OSelDr},
    '{1'b1, 1'b0,  6, OCapDr},
    '{1'b1, 1'b0,  2, OShDr},
    '{1'b1, 1'b1,  1, ODrIdle},
    '{1'b1, 1'b0,  3, ODrIdle},
    '{1'b1, 1'b0,  3, ODrIdle},
    '{1'b1, 1'b1,  0, ODrIdle},
    '{1'b1, 1'b0,  2, OShDr},
    '{1'b1, 1'b1,  1, ODrIdle},
    '{1'b1, 1'b1,  5, OUpdDr},
    '{1'b1, 1'b1,  7, OSelDr},
    '{1'b1, 1'b1,  4, OSelIr},
    '{1'b1, 1'b0, 14, OCapIr},
    '{1'b1, 1'b0, 10, OShIr},
    '{1'b0, 1'b0, 15, OTlr},
    '{1'b1, 1'b1, 15, OTlr},
    '{1'b1, 1'b0, 12, ORti}
  };

  function automatic logic [9:0] exp_out(input int s, input bit sync);
    logic cir;
    logic cdr;
    logic ir_col;
    ir_col = s inside {4, 8, 9, 10, 11, 13, 14};
    cir    = s inside {10, 14};
    cdr    = s inside {2, 6};
    if (!sync) begin
      cir = !cir;
      cdr = !cdr;
    end
    return {s != 15, s == 10, cir, s == 13, s == 2, cdr, s == 5, ir_col,
            (s == 10) || (s == 2), s == 12};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst_v, input bit tms_v);
    trst_n = rst_v;
    tms    = tms_v;
    @(posedge tck);
    if (!rst_v) m_state = 15;
    else        m_state = tms_v ? nxt1[m_state] : nxt0[m_state];
    #1;
  endtask

  task automatic check_model(input string tag);
    cmp({tag, "_dut0"}, 32'(out0), 32'(exp_out(m_state, 1'b1)));
    cmp({tag, "_dut1"}, 32'(out1), 32'(exp_out(m_state, 1'b0)));
`ifdef TAP_STATE_OBS_EN
    cmp({tag, "_state0"}, 32'(if0.tap_state), 32'(m_state));
    cmp({tag, "_state1"}, 32'(if1.tap_state), 32'(m_state));
`endif
  endtask

  initial begin
    trst_n = 1'b0;
    tms    = 1'b1;
    repeat (2) @(posedge tck);
    #1;

    // Directed vectors.
    for (int i = 0; i < 30; i++) begin
      step(vecs[i].rst_n, vecs[i].tms);
      cmp($sformatf("vec%0d_dut0", i), 32'(out0), 32'(vecs[i].out));
      cmp($sformatf("vec%0d_dut1", i), 32'(out1), 32'(vecs[i].out ^ InvMask));
`ifdef TAP_STATE_OBS_EN
      cmp($sformatf("vec%0d_state0", i), 32'(if0.tap_state), 32'(vecs[i].st));
      cmp($sformatf("vec%0d_state1", i), 32'(if1.tap_state), 32'(vecs[i].st));
`endif
    end

    // Five tms=1 edges reach TLR from every state.
    for (int s = 0; s < 16; s++) begin
      int n;
      step(1'b0, 1'b0);
      n = 0;
      while (m_state != s && n < 400) begin
        step(1'b1, 1'($urandom_range(0, 1)));
        n++;
      end
      checks++;
      if (m_state != s) begin
        errors++;
        $display("FAIL reach_state_%0d: got %0d expected %0d", s, m_state, s);
      end
      check_model($sformatf("at_state_%0d", s));
      repeat (5) step(1'b1, 1'b1);
      cmp($sformatf("five_ones_%0d_dut0", s), 32'(out0), 32'(OTlr));
      cmp($sformatf("five_ones_%0d_dut1", s), 32'(out1), 32'(OTlr ^ InvMask));
    end

    // Two hot bits in the one-hot register must decode as TLR.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    force dut1.r_state = 16'h0003;
    #1;
    cmp("illegal_onehot_dut1", 32'(out1), 32'(OTlr ^ InvMask));
    cmp("illegal_onehot_dut0", 32'(out0), 32'(OShIr));
    release dut1.r_state;
    step(1'b0, 1'b0);
    check_model("after_illegal");

    // Random tms with occasional reset against the reference model.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)));
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
